// File: rtl/pipe_id_operands_pkg.sv
// Shared definitions for the decode-stage operand block: forwarding select
// encodings and the hard-wired zero register index.
package pipe_id_operands_pkg;

  typedef enum logic [1:0] {
    FWD_ARRAY = 2'd0,
    FWD_EX    = 2'd1,
    FWD_MEM   = 2'd2,
    FWD_WB    = 2'd3
  } fwd_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         FWD_W    = 2;

endpackage

// File: rtl/pipe_id_operands_if.sv
// Bundle of the ID-stage operand request, pipeline producer taps and the
// resolved operand/hazard results exchanged with pipe_id_operands.
interface pipe_id_operands_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic [AW-1:0] IDrs;
  logic [AW-1:0] IDrt;
  logic          IDusesRs;
  logic          IDusesRt;

  logic          EXwreg;
  logic          EXm2reg;
  logic [AW-1:0] EXwn;
  logic [DW-1:0] EXaluResult;

  logic          MEMwreg;
  logic          MEMm2reg;
  logic [AW-1:0] MEMwn;
  logic [DW-1:0] MEMaluResult;
  logic [DW-1:0] MEMmemOut;

  logic          WBwreg;
  logic [AW-1:0] WBwn;
  logic [DW-1:0] WBdata;

  logic [DW-1:0] IDa;
  logic [DW-1:0] IDb;
  logic [1:0]    fwda;
  logic [1:0]    fwdb;
  logic          stall;

  // The pipeline side drives requests and producer state, the operand block answers.
  modport master (
    output IDrs, IDrt, IDusesRs, IDusesRt,
    output EXwreg, EXm2reg, EXwn, EXaluResult,
    output MEMwreg, MEMm2reg, MEMwn, MEMaluResult, MEMmemOut,
    output WBwreg, WBwn, WBdata,
    input  IDa, IDb, fwda, fwdb, stall
  );

  modport slave (
    input  IDrs, IDrt, IDusesRs, IDusesRt,
    input  EXwreg, EXm2reg, EXwn, EXaluResult,
    input  MEMwreg, MEMm2reg, MEMwn, MEMaluResult, MEMmemOut,
    input  WBwreg, WBwn, WBdata,
    output IDa, IDb, fwda, fwdb, stall
  );

endinterface

// File: rtl/pipe_id_operands_regfile_2r1w.sv
// General register array: two combinational read ports, one write port,
// asynchronous clear, r0 hard-wired to zero.
module regfile_2r1w
  import pipe_id_operands_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs [NREG];

  // Writes aimed at r0 are dropped so the array never holds a nonzero r0.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wn != AW'(REG_ZERO))) begin
      regs[wn] <= wd;
    end
  end

  assign qa = (ra == AW'(REG_ZERO)) ? '0 : regs[ra];
  assign qb = (rb == AW'(REG_ZERO)) ? '0 : regs[rb];

endmodule

// File: rtl/pipe_id_operands.sv
// Decode-stage operand source: register array plus EX/MEM/WB forwarding
// and load-use hazard detection.
module pipe_id_operands
  import pipe_id_operands_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic clk,
  input  logic clr,
  pipe_id_operands_if.slave bus
);

  logic [DW-1:0] arrA;
  logic [DW-1:0] arrB;
  logic [DW-1:0] memFwd;
  logic [DW-1:0] opA;
  logic [DW-1:0] opB;
  fwd_sel_e      selA;
  fwd_sel_e      selB;
  logic          hazard;

  regfile_2r1w #(
    .DW(DW),
    .AW(AW)
  ) u_regs (
    .clk(clk),
    .clr(clr),
    .we (bus.WBwreg),
    .wn (bus.WBwn),
    .wd (bus.WBdata),
    .ra (bus.IDrs),
    .rb (bus.IDrt),
    .qa (arrA),
    .qb (arrB)
  );

  // Youngest producer wins: EX, then MEM, then the write-back in flight.
  function automatic fwd_sel_e pickSource(
    input logic [AW-1:0] idx,
    input logic          exW,
    input logic [AW-1:0] exN,
    input logic          memW,
    input logic [AW-1:0] memN,
    input logic          wbW,
    input logic [AW-1:0] wbN
  );
    fwd_sel_e sel;
    sel = FWD_ARRAY;
    if (idx == AW'(REG_ZERO)) begin
      sel = FWD_ARRAY;
    end else if (exW && (exN == idx)) begin
      sel = FWD_EX;
    end else if (memW && (memN == idx)) begin
      sel = FWD_MEM;
    end else if (wbW && (wbN == idx)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  function automatic logic [DW-1:0] muxOperand(
    input fwd_sel_e      sel,
    input logic [DW-1:0] arr,
    input logic [DW-1:0] exVal,
    input logic [DW-1:0] memVal,
    input logic [DW-1:0] wbVal
  );
    logic [DW-1:0] val;
    case (sel)
      FWD_EX:  val = exVal;
      FWD_MEM: val = memVal;
      FWD_WB:  val = wbVal;
      default: val = arr;
    endcase
    return val;
  endfunction

  assign memFwd = bus.MEMm2reg ? bus.MEMmemOut : bus.MEMaluResult;

  always_comb begin
    selA = pickSource(bus.IDrs, bus.EXwreg, bus.EXwn, bus.MEMwreg, bus.MEMwn,
                      bus.WBwreg, bus.WBwn);
    selB = pickSource(bus.IDrt, bus.EXwreg, bus.EXwn, bus.MEMwreg, bus.MEMwn,
                      bus.WBwreg, bus.WBwn);
    opA  = muxOperand(selA, arrA, bus.EXaluResult, memFwd, bus.WBdata);
    opB  = muxOperand(selB, arrB, bus.EXaluResult, memFwd, bus.WBdata);
  end

  // Only a load still in EX stalls; a load in MEM is covered by forwarding MEMmemOut.
  always_comb begin
    hazard = bus.EXwreg && bus.EXm2reg && (bus.EXwn != AW'(REG_ZERO)) &&
             ((bus.IDusesRs && (bus.EXwn == bus.IDrs)) ||
              (bus.IDusesRt && (bus.EXwn == bus.IDrt)));
  end

  // Outputs are forced quiet while clear is held, whatever the pipeline presents.
  assign bus.IDa   = clr ? '0 : opA;
  assign bus.IDb   = clr ? '0 : opB;
  assign bus.fwda  = clr ? FWD_ARRAY : selA;
  assign bus.fwdb  = clr ? FWD_ARRAY : selB;
  assign bus.stall = !clr && hazard;

endmodule

// File: tb/tb_pipe_id_operands.sv
// Self-checking bench for pipe_id_operands: directed scenarios plus a
// randomized phase checked against a reference register model.
module tb_pipe_id_operands;

  logic clk;
  logic clr;

  int testsRun;
  int testsFailed;

  pipe_id_operands_if #(.DW(32), .AW(5)) bus ();

  pipe_id_operands #(.DW(32), .AW(5)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  fa;
    logic [31:0] b;
    logic [1:0]  fb;
    logic        st;
    logic        chkOps;
  } expect_t;

  expect_t expQ[$];
  string   tagQ[$];

  logic [31:0] refRegs [32];

  // Reference array: same write rules, kept independently of the DUT.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) refRegs[i] <= 32'd0;
    end else if (bus.WBwreg && (bus.WBwn != 5'd0)) begin
      refRegs[bus.WBwn] <= bus.WBdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drainScoreboard();
    expect_t e;
    string   t;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      if (e.chkOps) begin
        checkOutput({t, ".IDa"},  bus.IDa, e.a);
        checkOutput({t, ".fwda"}, {30'd0, bus.fwda}, {30'd0, e.fa});
        checkOutput({t, ".IDb"},  bus.IDb, e.b);
        checkOutput({t, ".fwdb"}, {30'd0, bus.fwdb}, {30'd0, e.fb});
      end
      checkOutput({t, ".stall"}, {31'd0, bus.stall}, {31'd0, e.st});
    end
  endtask

  // Caller has already driven the inputs; record expectations and compare once settled.
  task automatic applyStimulus(input string tag,
                               input logic [31:0] ea, input logic [1:0] efa,
                               input logic [31:0] eb, input logic [1:0] efb,
                               input logic est, input logic chkOps);
    expect_t e;
    e.a = ea; e.fa = efa; e.b = eb; e.fb = efb; e.st = est; e.chkOps = chkOps;
    expQ.push_back(e);
    tagQ.push_back(tag);
    #1;
    drainScoreboard();
  endtask

  task automatic idleInputs();
    bus.IDrs = 5'd0;        bus.IDrt = 5'd0;
    bus.IDusesRs = 1'b0;    bus.IDusesRt = 1'b0;
    bus.EXwreg = 1'b0;      bus.EXm2reg = 1'b0;
    bus.EXwn = 5'd0;        bus.EXaluResult = 32'd0;
    bus.MEMwreg = 1'b0;     bus.MEMm2reg = 1'b0;
    bus.MEMwn = 5'd0;       bus.MEMaluResult = 32'd0;
    bus.MEMmemOut = 32'd0;
    bus.WBwreg = 1'b0;      bus.WBwn = 5'd0;
    bus.WBdata = 32'd0;
  endtask

  task automatic modelOperand(input logic [4:0] idx, output logic [31:0] d, output logic [1:0] s);
    d = refRegs[idx];
    s = 2'd0;
    if (idx == 5'd0) begin
      d = 32'd0;
    end else if (bus.EXwreg && bus.EXwn == idx) begin
      d = bus.EXaluResult; s = 2'd1;
    end else if (bus.MEMwreg && bus.MEMwn == idx) begin
      d = bus.MEMm2reg ? bus.MEMmemOut : bus.MEMaluResult; s = 2'd2;
    end else if (bus.WBwreg && bus.WBwn == idx) begin
      d = bus.WBdata; s = 2'd3;
    end
  endtask

  task automatic writeReg(input logic [4:0] n, input logic [31:0] d);
    @(negedge clk);
    idleInputs();
    bus.WBwreg = 1'b1; bus.WBwn = n; bus.WBdata = d;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ea, eb;
    logic [1:0]  sa, sb;
    logic        est;

    testsRun = 0;
    testsFailed = 0;

    // Reset held with a hazard and a WB match presented: outputs must stay quiet.
    clr = 1'b1;
    idleInputs();
    bus.IDrs = 5'd3; bus.IDrt = 5'd3; bus.IDusesRs = 1'b1;
    bus.EXwreg = 1'b1; bus.EXm2reg = 1'b1; bus.EXwn = 5'd3; bus.EXaluResult = 32'h55;
    bus.WBwreg = 1'b1; bus.WBwn = 5'd3; bus.WBdata = 32'h77;
    applyStimulus("reset", 32'd0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    idleInputs();

    // r0 write attempt is discarded.
    writeReg(5'd0, 32'hDEADBEEF);
    applyStimulus("r0_write", 32'd0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);
    @(negedge clk); idleInputs();
    applyStimulus("r0_read", 32'd0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);

    // Write r5, then read it from the array while r6 is written through.
    writeReg(5'd5, 32'h12345678);
    bus.IDrs = 5'd5;
    applyStimulus("r5_wt", 32'h12345678, 2'd3, 32'd0, 2'd0, 1'b0, 1'b1);
    writeReg(5'd6, 32'hA5A5A5A5);
    bus.IDrs = 5'd5; bus.IDrt = 5'd6;
    applyStimulus("r5_arr_r6_wt", 32'h12345678, 2'd0, 32'hA5A5A5A5, 2'd3, 1'b0, 1'b1);
    @(negedge clk); idleInputs();
    bus.IDrt = 5'd6;
    applyStimulus("r6_arr", 32'd0, 2'd0, 32'hA5A5A5A5, 2'd0, 1'b0, 1'b1);

    // Priority among EX, MEM and WB for the same index.
    @(negedge clk); idleInputs();
    bus.EXwreg = 1'b1;  bus.EXwn = 5'd7;  bus.EXaluResult = 32'd1;
    bus.MEMwreg = 1'b1; bus.MEMwn = 5'd7; bus.MEMaluResult = 32'd2;
    bus.WBwreg = 1'b1;  bus.WBwn = 5'd7;  bus.WBdata = 32'd3;
    bus.IDrs = 5'd7; bus.IDrt = 5'd7;
    applyStimulus("prio_ex", 32'd1, 2'd1, 32'd1, 2'd1, 1'b0, 1'b1);
    bus.EXwreg = 1'b0;
    applyStimulus("prio_mem", 32'd2, 2'd2, 32'd2, 2'd2, 1'b0, 1'b1);
    bus.MEMwreg = 1'b0;
    applyStimulus("prio_wb", 32'd3, 2'd3, 32'd3, 2'd3, 1'b0, 1'b1);
    @(negedge clk); idleInputs();
    bus.IDrs = 5'd7;
    applyStimulus("r7_arr", 32'd3, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);

    // Load in MEM forwards memory data and never stalls.
    @(negedge clk); idleInputs();
    bus.MEMwreg = 1'b1; bus.MEMm2reg = 1'b1; bus.MEMwn = 5'd9;
    bus.MEMmemOut = 32'hCAFE0000; bus.MEMaluResult = 32'h100;
    bus.IDrt = 5'd9; bus.IDusesRt = 1'b1;
    applyStimulus("mem_load", 32'd0, 2'd0, 32'hCAFE0000, 2'd2, 1'b0, 1'b1);

    // Load-use hazard cases.
    @(negedge clk); idleInputs();
    bus.EXwreg = 1'b1; bus.EXm2reg = 1'b1; bus.EXwn = 5'd4; bus.EXaluResult = 32'h44;
    bus.IDrs = 5'd4; bus.IDusesRs = 1'b1;
    applyStimulus("stall_rs", 32'd0, 2'd0, 32'd0, 2'd0, 1'b1, 1'b0);
    bus.IDusesRs = 1'b0;
    applyStimulus("nostall_unused", 32'h44, 2'd1, 32'd0, 2'd0, 1'b0, 1'b1);
    bus.IDrs = 5'd1; bus.IDrt = 5'd4; bus.IDusesRt = 1'b1;
    applyStimulus("stall_rt", 32'd0, 2'd0, 32'd0, 2'd0, 1'b1, 1'b0);
    bus.EXwn = 5'd0; bus.IDrs = 5'd0; bus.IDrt = 5'd0;
    bus.IDusesRs = 1'b1; bus.IDusesRt = 1'b1;
    applyStimulus("nostall_r0", 32'd0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);

    // Reset mid-run: clears the array immediately and swallows a WB write.
    writeReg(5'd1, 32'h11);
    writeReg(5'd2, 32'h22);
    writeReg(5'd3, 32'h33);
    @(negedge clk); idleInputs();
    bus.IDrs = 5'd1; bus.IDrt = 5'd3;
    applyStimulus("pre_clr", 32'h11, 2'd0, 32'h33, 2'd0, 1'b0, 1'b1);
    #1;
    bus.WBwreg = 1'b1; bus.WBwn = 5'd3; bus.WBdata = 32'hFFFF0000;
    clr = 1'b1;
    applyStimulus("clr_mid", 32'd0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    clr = 1'b0;
    idleInputs();
    bus.IDrs = 5'd3; bus.IDrt = 5'd2;
    applyStimulus("post_clr_r3_r2", 32'd0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);
    bus.IDrs = 5'd1;
    applyStimulus("post_clr_r1", 32'd0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);

    // Randomized traffic over a small index range to force frequent collisions.
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      bus.IDrs = 5'($urandom_range(0, 7));
      bus.IDrt = 5'($urandom_range(0, 7));
      bus.IDusesRs = 1'($urandom_range(0, 1));
      bus.IDusesRt = 1'($urandom_range(0, 1));
      bus.EXwreg = 1'($urandom_range(0, 1));
      bus.EXm2reg = ($urandom_range(0, 3) == 0);
      bus.EXwn = 5'($urandom_range(0, 7));
      bus.EXaluResult = $urandom;
      bus.MEMwreg = 1'($urandom_range(0, 1));
      bus.MEMm2reg = 1'($urandom_range(0, 1));
      bus.MEMwn = 5'($urandom_range(0, 7));
      bus.MEMaluResult = $urandom;
      bus.MEMmemOut = $urandom;
      bus.WBwreg = 1'($urandom_range(0, 1));
      bus.WBwn = 5'($urandom_range(0, 7));
      bus.WBdata = $urandom;
      modelOperand(bus.IDrs, ea, sa);
      modelOperand(bus.IDrt, eb, sb);
      est = bus.EXwreg && bus.EXm2reg && (bus.EXwn != 5'd0) &&
            ((bus.IDusesRs && bus.EXwn == bus.IDrs) || (bus.IDusesRt && bus.EXwn == bus.IDrt));
      applyStimulus($sformatf("rand%0d", n), ea, sa, eb, sb, est, !est);
    end

    @(negedge clk);
    idleInputs();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
